// File: rtl/seven_segment_scan_driver.sv
// seven_segment_scan_driver
// Time-multiplexed common-anode 7-segment driver. A packed hex value is
// staged in a pending register and promoted to the displayed copy only at
// frame boundaries, so a frame never mixes old and new digits. Each digit
// slot opens with GUARD cycles of dark anodes to suppress ghosting.

module seven_segment_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_done
);

    localparam int IW = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
    localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [6:0]            SEG_OFF   = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF    = ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = ACTIVE_LOW ? '1 : '0;
    localparam logic [TW-1:0]         TICK_LAST = TW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [TW-1:0]           tick;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] pending_val;
    logic [NUM_DIGITS-1:0]   pending_dp;
    logic [4*NUM_DIGITS-1:0] shown_val;
    logic [NUM_DIGITS-1:0]   shown_dp;

    logic                    tick_wrap;
    logic                    boundary;
    logic                    in_guard;
    logic [3:0]              cur_nibble;
    logic [6:0]              cur_raw;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [NUM_DIGITS-1:0]   onehot;

    assign tick_wrap = (tick == TICK_LAST);
    assign boundary  = tick_wrap && (idx == IDX_LAST);
    assign in_guard  = (int'(tick) < GUARD);
    assign onehot    = NUM_DIGITS'(1) << idx;

    // Select the nibble of the digit currently being scanned
    always_comb begin
        cur_nibble = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nibble = shown_val[4*i +: 4];
            end
        end
    end

    // Hex to active-high {g,f,e,d,c,b,a}
    always_comb begin
        cur_raw = 7'h00;
        case (cur_nibble)
            4'h0: cur_raw = 7'h3F;
            4'h1: cur_raw = 7'h06;
            4'h2: cur_raw = 7'h5B;
            4'h3: cur_raw = 7'h4F;
            4'h4: cur_raw = 7'h66;
            4'h5: cur_raw = 7'h6D;
            4'h6: cur_raw = 7'h7D;
            4'h7: cur_raw = 7'h07;
            4'h8: cur_raw = 7'h7F;
            4'h9: cur_raw = 7'h6F;
            4'hA: cur_raw = 7'h77;
            4'hB: cur_raw = 7'h7C;
            4'hC: cur_raw = 7'h39;
            4'hD: cur_raw = 7'h5E;
            4'hE: cur_raw = 7'h79;
            default: cur_raw = 7'h71;
        endcase
    end

    // Leading-zero mask: walk down from the top digit while everything seen is zero
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (shown_val[4*i +: 4] == 4'h0);
            lz_blank[i] = all_zero && (i != 0);
        end
    end

    // Scan position: tick within a slot, idx selects the digit
    always_ff @(posedge clk) begin
        if (reset) begin
            tick <= '0;
            idx  <= '0;
        end else if (tick_wrap) begin
            tick <= '0;
            idx  <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            tick <= tick + TW'(1);
        end
    end

    // Double-buffered display data; a load on the boundary goes straight to the shown copy
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_val <= '0;
            pending_dp  <= '0;
            shown_val   <= '0;
            shown_dp    <= '0;
        end else begin
            if (load) begin
                pending_val <= value;
                pending_dp  <= dp_in;
            end
            if (boundary) begin
                shown_val <= load ? value : pending_val;
                shown_dp  <= load ? dp_in : pending_dp;
            end
        end
    end

    // Registered pin drive, one cycle behind the scan position
    always_ff @(posedge clk) begin
        if (reset) begin
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            anode      <= ANODE_OFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (blank_lz && lz_blank[idx]) begin
                seg <= SEG_OFF;
            end else begin
                seg <= ACTIVE_LOW ? ~cur_raw : cur_raw;
            end
            dp    <= ACTIVE_LOW ? ~shown_dp[idx] : shown_dp[idx];
            anode <= in_guard ? ANODE_OFF : (ACTIVE_LOW ? ~onehot : onehot);
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Bench for seven_segment_scan_driver: directed scenarios followed by a
// randomized run, every cycle compared against a cycle-count based model.

module tb_seven_segment_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int GRD   = 1;
    localparam int FRAME = N * DIV;

    localparam logic [6:0] DEC [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load = 1'b0;
    logic [15:0]   value = '0;
    logic [3:0]    dp_in = '0;
    logic          blank_lz = 1'b0;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    anode;
    logic          frame_done;

    int tests = 0;
    int fails = 0;

    // model: cycles since reset release, staged and displayed data
    int          m_t = 0;
    logic [15:0] m_pend_v = '0;
    logic [3:0]  m_pend_dp = '0;
    logic [15:0] m_shown_v = '0;
    logic [3:0]  m_shown_dp = '0;
    int          fd_seen = 0;

    seven_segment_scan_driver #(
        .NUM_DIGITS (N),
        .REFRESH_DIV(DIV),
        .GUARD      (GRD),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .value     (value),
        .dp_in     (dp_in),
        .blank_lz  (blank_lz),
        .seg       (seg),
        .dp        (dp),
        .anode     (anode),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic step(input logic rst, input logic ld, input logic [15:0] v,
                        input logic [3:0] d, input logic bl);
        logic [6:0] e_seg;
        logic       e_dp;
        logic [3:0] e_an;
        logic       e_fd;
        int         di;
        int         tk;
        int         upper;
        bit         bnd;
        reset = rst; load = ld; value = v; dp_in = d; blank_lz = bl;
        bnd = 1'b0;
        if (rst) begin
            e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fd = 1'b0;
        end else begin
            di    = (m_t / DIV) % N;
            tk    = m_t % DIV;
            upper = int'(m_shown_v >> (4 * di));
            if (bl && di != 0 && upper == 0) e_seg = 7'h7F;
            else                             e_seg = ~DEC[upper % 16];
            e_dp  = ~m_shown_dp[di];
            e_an  = (tk < GRD) ? 4'hF : ~(4'(1) << di);
            bnd   = ((m_t + 1) % FRAME) == 0;
            e_fd  = bnd;
        end
        @(posedge clk);
        #1;
        tests++;
        assert (seg === e_seg) else begin
            fails++; $error("FAIL seg t=%0d observed=%h expected=%h", m_t, seg, e_seg);
        end
        tests++;
        assert (dp === e_dp) else begin
            fails++; $error("FAIL dp t=%0d observed=%b expected=%b", m_t, dp, e_dp);
        end
        tests++;
        assert (anode === e_an) else begin
            fails++; $error("FAIL anode t=%0d observed=%h expected=%h", m_t, anode, e_an);
        end
        tests++;
        assert (frame_done === e_fd) else begin
            fails++; $error("FAIL frame_done t=%0d observed=%b expected=%b", m_t, frame_done, e_fd);
        end
        if (frame_done === 1'b1) fd_seen++;
        if (rst) begin
            m_t = 0; m_pend_v = '0; m_pend_dp = '0; m_shown_v = '0; m_shown_dp = '0;
        end else begin
            if (bnd) begin
                m_shown_v  = ld ? v : m_pend_v;
                m_shown_dp = ld ? d : m_pend_dp;
            end
            if (ld) begin
                m_pend_v = v; m_pend_dp = d;
            end
            m_t++;
        end
    endtask

    task automatic idle(input int n, input logic bl);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 4'h0, bl);
    endtask

    initial begin
        int fd_start;
        logic bl_r;

        // reset held three cycles
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);

        // first cycle after release: digit 0 of 0000, guard cycle
        step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
        tests++;
        assert (seg === 7'h40) else begin
            fails++; $error("FAIL first_digit0 observed=%h expected=40", seg);
        end

        // mid-frame load, old value must persist until the boundary
        idx_wait: idle(5, 1'b0);
        step(1'b0, 1'b1, 16'h12AF, 4'h0, 1'b0);
        idle(2 * FRAME, 1'b0);

        // frame_done period over ten frames
        fd_start = fd_seen;
        idle(10 * FRAME, 1'b0);
        tests++;
        assert (fd_seen - fd_start === 10) else begin
            fails++; $error("FAIL frame_count observed=%0d expected=10", fd_seen - fd_start);
        end

        // leading-zero blanking and dp independence from blanking
        step(1'b0, 1'b1, 16'h0050, 4'h0, 1'b1);
        idle(2 * FRAME, 1'b1);
        step(1'b0, 1'b1, 16'h0000, 4'b0100, 1'b1);
        idle(2 * FRAME, 1'b1);

        // load coincident with the frame boundary
        while ((m_t + 1) % FRAME != 0) step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
        step(1'b0, 1'b1, 16'h9C3E, 4'b1001, 1'b0);
        idle(DIV, 1'b0);
        tests++;
        assert (seg === ~7'h79) else begin
            fails++; $error("FAIL boundary_load_digit0 observed=%h expected=%h", seg, ~7'h79);
        end
        idle(FRAME, 1'b0);

        // reset pulsed during digit 2's slot
        while (((m_t / DIV) % N) != 2 || (m_t % DIV) != 1) step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        idle(2 * FRAME, 1'b1);

        // randomized traffic
        bl_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) bl_r = ~bl_r;
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0),
                 16'($urandom), 4'($urandom), bl_r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
